// File: rtl/dot_accum_12.sv
// Accumulate NUM_PART signed partial dot products, add bias, optional ReLU,
// saturate to data_len bits and emit one registered result per group.
`ifndef DATA_LEN
`define DATA_LEN 16
`endif

module dot_accum_12 #(
    parameter int unsigned                   NUM_PART = 3,
    parameter logic signed [`DATA_LEN-1:0]   BIAS     = '0,
    parameter bit                            RELU_EN  = 1'b1,
    parameter int unsigned                   ACC_EXT  = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clr,
    input  logic                         in_valid,
    input  logic signed [`DATA_LEN-1:0]  in_data,
    output logic                         out_valid,
    output logic signed [`DATA_LEN-1:0]  out_data,
    output logic                         out_sat,
    output logic                         busy
);

    localparam int unsigned DW = `DATA_LEN;
    localparam int unsigned AW = DW + ACC_EXT;
    localparam int unsigned CW = 3;

    localparam logic signed [AW-1:0] T_MAX = {{(ACC_EXT+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [AW-1:0] T_MIN = {{(ACC_EXT+1){1'b1}}, {(DW-1){1'b0}}};
    localparam logic signed [DW-1:0] D_MAX = {1'b0, {(DW-1){1'b1}}};
    localparam logic signed [DW-1:0] D_MIN = {1'b1, {(DW-1){1'b0}}};

    if (NUM_PART < 1 || NUM_PART > 8) begin : g_bad_num_part
        $error("dot_accum_12: NUM_PART must be in 1..8");
    end
    if (ACC_EXT < $clog2(NUM_PART + 1)) begin : g_bad_acc_ext
        $error("dot_accum_12: ACC_EXT too small for NUM_PART plus bias");
    end

    logic [CW-1:0]          part_cnt_q, part_cnt_d;
    logic signed [AW-1:0]   acc_q, acc_d;
    logic signed [AW-1:0]   sum_q, sum_d;
    logic                   pend_q, pend_d;
    logic                   out_valid_q, out_valid_d;
    logic signed [DW-1:0]   out_data_q, out_data_d;
    logic                   out_sat_q, out_sat_d;
    logic                   busy_q, busy_d;

    logic signed [AW-1:0]   in_ext;
    logic signed [AW-1:0]   acc_next;
    logic signed [AW-1:0]   t_full;
    logic                   part_last;

    assign in_ext    = AW'(in_data);
    assign part_last = (part_cnt_q == CW'(NUM_PART - 1));
    assign acc_next  = (part_cnt_q == '0) ? in_ext : (acc_q + in_ext);
    assign t_full    = sum_q + AW'(BIAS);

    // Stage 1: group accumulation; clr drops the partial group and any same-cycle input.
    always_comb begin
        part_cnt_d = part_cnt_q;
        acc_d      = acc_q;
        sum_d      = sum_q;
        pend_d     = 1'b0;
        if (clr) begin
            part_cnt_d = '0;
        end else if (in_valid) begin
            acc_d = acc_next;
            if (part_last) begin
                part_cnt_d = '0;
                sum_d      = acc_next;
                pend_d     = 1'b1;
            end else begin
                part_cnt_d = part_cnt_q + CW'(1);
            end
        end
    end

    // Stage 2: bias, ReLU and saturation; data/sat hold between pulses.
    always_comb begin
        out_valid_d = pend_q;
        out_data_d  = out_data_q;
        out_sat_d   = out_sat_q;
        if (pend_q) begin
            if (RELU_EN && (t_full < 0)) begin
                out_data_d = '0;
                out_sat_d  = 1'b0;
            end else if (t_full > T_MAX) begin
                out_data_d = D_MAX;
                out_sat_d  = 1'b1;
            end else if (t_full < T_MIN) begin
                out_data_d = D_MIN;
                out_sat_d  = 1'b1;
            end else begin
                out_data_d = DW'(t_full);
                out_sat_d  = 1'b0;
            end
        end
        busy_d = (part_cnt_d != '0) | pend_d | out_valid_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            part_cnt_q  <= '0;
            acc_q       <= '0;
            sum_q       <= '0;
            pend_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            part_cnt_q  <= part_cnt_d;
            acc_q       <= acc_d;
            sum_q       <= sum_d;
            pend_q      <= pend_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sat_q   <= out_sat_d;
            busy_q      <= busy_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sat   = out_sat_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_dot_accum_12.sv
// Scoreboard bench: four dot_accum_12 instances (different BIAS/RELU_EN) share
// one directed stimulus stream; a negedge monitor checks each output pulse.
module tb_dot_accum_12;

    // Instance configs: 0 = bias 5/ReLU, 1 = bias -10/ReLU, 2 = bias -10/no ReLU, 3 = bias 0/no ReLU
    localparam logic [3:0][15:0] BIAS_T = {16'h0000, 16'hFFF6, 16'hFFF6, 16'h0005};
    localparam logic [3:0]       RELU_T = 4'b0011;

    typedef struct packed {
        logic [3:0][15:0] d;
        logic [3:0]       s;
        int unsigned      cyc;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              clr;
    logic              in_valid;
    logic signed [15:0] in_data;
    logic [3:0]        ov;
    logic [3:0][15:0]  od;
    logic [3:0]        os;
    logic [3:0]        bsy;

    int unsigned cyc_q = 0;
    int          n_chk = 0;
    int          n_fail = 0;
    exp_t        exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc_q <= cyc_q + 1;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        dot_accum_12 #(
            .NUM_PART (3),
            .BIAS     (BIAS_T[g]),
            .RELU_EN  (RELU_T[g]),
            .ACC_EXT  (4)
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .clr       (clr),
            .in_valid  (in_valid),
            .in_data   (in_data),
            .out_valid (ov[g]),
            .out_data  (od[g]),
            .out_sat   (os[g]),
            .busy      (bsy[g])
        );
    end

    task automatic chk(input string name, input int act, input int req);
        n_chk++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc_q);
        end
    endtask

    // Monitor: every output pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (|ov) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_pulse", int'(ov), 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("pulse_cycle", int'(cyc_q), int'(e.cyc));
                chk("valid_all", int'(ov), 15);
                for (int i = 0; i < 4; i++) begin
                    chk($sformatf("data[%0d]", i), int'($signed(od[i])), int'($signed(e.d[i])));
                    chk($sformatf("sat[%0d]", i), int'(os[i]), int'(e.s[i]));
                end
            end
        end
    end

    task automatic send(input int v);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 16'(v);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            clr      = 1'b0;
            rst      = 1'b0;
        end
    endtask

    // Call right after the last partial of a group is driven.
    task automatic push(input int a, input int b, input int c, input int d, input logic [3:0] s);
        exp_t e;
        e.d   = {16'(d), 16'(c), 16'(b), 16'(a)};
        e.s   = s;
        e.cyc = cyc_q + 2;
        exp_q.push_back(e);
    endtask

    task automatic chk_zero(input string name);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("%s_data[%0d]", name, i), int'($signed(od[i])), 0);
        end
        chk({name, "_sat"}, int'(os), 0);
        chk({name, "_valid"}, int'(ov), 0);
        chk({name, "_busy"}, int'(bsy), 0);
    endtask

    initial begin
        rst = 1'b1; clr = 1'b0; in_valid = 1'b0; in_data = '0;
        repeat (3) @(negedge clk);
        chk_zero("reset");
        idle(2);

        // Basic: 100+200-50 = 250
        send(100);
        send(200);
        chk("busy_mid_group", int'(bsy), 15);
        send(-50);
        push(255, 240, 240, 250, 4'b0000);
        idle(3);
        chk("busy_after", int'(bsy), 0);
        chk("hold_data0", int'($signed(od[0])), 255);

        // Positive saturation: 90000
        send(30000); send(30000); send(30000);
        push(32767, 32767, 32767, 32767, 4'b1111);
        // Negative saturation: -90000 (ReLU instances zero, no sat)
        send(-30000); send(-30000); send(-30000);
        push(0, 0, -32768, -32768, 4'b1100);
        // ReLU edge: 9, bias -10 -> -1
        send(3); send(3); send(3);
        push(14, 0, -1, 9, 4'b0000);
        idle(4);

        // Back-to-back groups 1..12
        send(1); send(2); send(3);    push(11, 0, -4, 6, 4'b0000);
        send(4); send(5); send(6);    push(20, 5, 5, 15, 4'b0000);
        send(7); send(8); send(9);    push(29, 14, 14, 24, 4'b0000);
        send(10); send(11); send(12); push(38, 23, 23, 33, 4'b0000);
        idle(4);

        // clr drops two partials and its own same-cycle partial, then gapped group
        send(50); send(60);
        @(negedge clk); clr = 1'b1; in_valid = 1'b1; in_data = 16'sd70;
        @(negedge clk); clr = 1'b0; in_valid = 1'b0;
        send(7); idle(1); send(8); idle(1); send(9);
        push(29, 14, 14, 24, 4'b0000);
        idle(4);

        // Exact positive and negative limits
        send(32000); send(767); send(0);
        push(32767, 32757, 32757, 32767, 4'b0001);
        send(-32000); send(-768); send(0);
        push(0, 0, -32768, -32768, 4'b0100);
        idle(4);

        // Reset mid-group (with in_valid asserted during reset)
        send(1); send(2);
        @(negedge clk); rst = 1'b1; in_valid = 1'b1; in_data = 16'sd99;
        @(negedge clk); rst = 1'b0; in_valid = 1'b0;
        chk_zero("rst_mid");
        // Reset one cycle after a group's last partial: pending result dropped
        send(5); send(5); send(5);
        @(negedge clk); rst = 1'b1; in_valid = 1'b0;
        @(negedge clk); rst = 1'b0;
        chk_zero("rst_pend");
        idle(3);
        chk_zero("rst_quiet");

        send(1); send(1); send(1);
        push(8, 0, -7, 3, 4'b0000);
        idle(6);

        chk("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
